fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controller that sequences the instruction-fetch datapath (PC register, PC+4 incrementer, byte-addressed little-endian instruction memory).
- Owns the PC and issues fetch requests to instruction memory over a req/ready handshake.
- Presents fetched instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects and a misaligned-target error.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
ADDR_W, 32, width of PC and memory address.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  ADDR_W  byte address of requested word; equals current PC.
imem_ready  input  1  memory accepts request and returns data this cycle; transfer occurs when imem_req && imem_ready.
imem_rdata  input  32  instruction word, valid in the transfer cycle.
redirect  input  1  load a new PC (taken branch/jump); single-cycle pulse.
redirect_pc  input  ADDR_W  redirect target.
if_valid  output  1  if_instr/if_pc hold a valid instruction.
if_instr  output  32  fetched instruction.
if_pc  output  ADDR_W  address of if_instr.
if_ready  input  1  decode accepts; handoff when if_valid && if_ready.
misalign_err  output  1  sticky: redirect target not 4-byte aligned.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, pc=RESET_PC, imem_req=0, if_valid=0, if_instr=0, if_pc=0, misalign_err=0.
- States: IDLE, FETCH, HOLD, ERROR. All outputs are registered except imem_addr=pc and imem_req=(state==FETCH).
- IDLE: one cycle after reset release -> FETCH.
- FETCH: imem_req=1, imem_addr=pc held stable until transfer.
  - On transfer: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (mod 2^ADDR_W; 32'hFFFF_FFFC wraps to 0), -> HOLD.
- HOLD: imem_req=0, output register stable.
  - On if_ready: if_valid<=0, -> FETCH.
  - Steady-state throughput: 1 instruction per 2 cycles when memory and decode are always ready.
- Only one outstanding fetch. Memory samples imem_addr only in the transfer cycle, so the address may change while no transfer has occurred.
- redirect=1, aligned target, any state except ERROR:
  - Highest priority: pc<=redirect_pc, if_valid<=0, -> FETCH next cycle.
  - Overrides a same-cycle transfer: imem_rdata is discarded, pc is not incremented.
  - Overrides a same-cycle if_ready.
- redirect=1 with redirect_pc[1:0]!=0:
  - misalign_err<=1, if_valid<=0, pc unchanged, -> ERROR.
  - ERROR: imem_req=0, if_valid=0; redirects ignored; exit only via reset.
- redirect asserted during reset is ignored.
- Reset mid-transfer: all state cleared immediately; the transfer is abandoned.

Test Plan:
1. Reset release, imem_ready=1, if_ready=1, memory holding words 0xFFC41303, 0x0064A423, 0x0062E233, 0xFE420AE3 -> 4 handoffs carrying if_pc 0,4,8,12 with those words; if_valid pulses on alternate cycles; imem_addr=0 on the first FETCH cycle.
2. imem_ready held low for 3 cycles in FETCH -> imem_req=1, imem_addr constant for all 4 cycles; single transfer on cycle 4; pc advances by exactly 4.
3. if_ready=0 for 5 cycles while in HOLD -> if_valid, if_instr, if_pc stable; imem_req=0; no pc change; next fetch starts the cycle after if_ready=1.
4. redirect to 0x40 in the same cycle as a transfer at pc=8 -> data discarded, no handoff of pc 8; next imem_addr=0x40; next if_pc=0x40.
5. redirect_pc=0x42 -> misalign_err=1 next cycle, state ERROR, imem_req=0 thereafter, a later aligned redirect has no effect; reset_n low clears misalign_err and fetch restarts at RESET_PC.
6. Redirect to 0xFFFF_FFFC, fetch completes -> next imem_addr=0x0000_0000 (wrap). Assert reset_n=0 mid-FETCH -> imem_req and if_valid drop without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues single-outstanding fetches to
// instruction memory and hands fetched words to decode, with redirect and misalign trap.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              if_ready,
    output logic              misalign_err,
    output logic [1:0]        dbg_state
);

    // Handshakes: a memory transfer happens on imem_req && imem_ready, a decode
    // handoff on if_valid && if_ready; the initiator holds its payload stable until then.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;

    assign imem_addr = pc;
    assign imem_req  = (state == FETCH);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pc           <= RESET_PC[ADDR_W-1:0];
            if_valid     <= 1'b0;
            if_instr     <= 32'h0;
            if_pc        <= '0;
            misalign_err <= 1'b0;
        end else if (redirect && state != ERROR) begin
            // Redirect beats any same-cycle transfer or decode handoff.
            if_valid <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
                state        <= ERROR;
            end else begin
                pc    <= redirect_pc;
                state <= FETCH;
            end
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (imem_ready) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= pc + ADDR_W'(4);
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (if_ready) begin
                        if_valid <= 1'b0;
                        state    <= FETCH;
                    end
                end
                ERROR: begin
                    if_valid <= 1'b0;
                    state    <= ERROR;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one task per scenario, each with inline checks
// against hand-computed values; memory is a small behavioural table.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b0;
    logic        misalign_err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2, S_ERROR = 2'd3;

    fetch_sequencer #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .misalign_err(misalign_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Program words at 0..12; every other address returns the bitwise inverse of itself.
    always_comb begin
        case (imem_addr)
            32'h0:   imem_rdata = 32'hFFC4_1303;
            32'h4:   imem_rdata = 32'h0064_A423;
            32'h8:   imem_rdata = 32'h0062_E233;
            32'hC:   imem_rdata = 32'hFE42_0AE3;
            default: imem_rdata = ~imem_addr;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", if_instr); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL rst_if_pc got=%h exp=0", if_pc); end
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", misalign_err); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    endtask

    task automatic test_stream();
        logic [31:0] words [4];
        words[0] = 32'hFFC4_1303;
        words[1] = 32'h0064_A423;
        words[2] = 32'h0062_E233;
        words[3] = 32'hFE42_0AE3;
        imem_ready = 1'b1;
        if_ready = 1'b1;
        reset_n = 1'b1;
        checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL t1_idle got=%0d exp=%0d", dbg_state, S_IDLE); end
        tick();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL t1_first_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL t1_first_addr got=%h exp=0", imem_addr); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL t1_valid[%0d] got=%b exp=1", i, if_valid); end
            checks++; if (if_pc !== 32'(4 * i)) begin failures++; $display("FAIL t1_pc[%0d] got=%h exp=%h", i, if_pc, 32'(4 * i)); end
            checks++; if (if_instr !== words[i]) begin failures++; $display("FAIL t1_instr[%0d] got=%h exp=%h", i, if_instr, words[i]); end
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL t1_hold_req[%0d] got=%b exp=0", i, imem_req); end
            tick();
            checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL t1_gap[%0d] got=%b exp=0", i, if_valid); end
            checks++; if (imem_addr !== 32'(4 * i + 4)) begin failures++; $display("FAIL t1_next_addr[%0d] got=%h exp=%h", i, imem_addr, 32'(4 * i + 4)); end
        end
    endtask

    task automatic test_mem_stall();
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin failures++; $display("FAIL t2_stall[%0d] got req=%b addr=%h exp req=1 addr=10", k, imem_req, imem_addr); end
            tick();
        end
        checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin failures++; $display("FAIL t2_cycle4 got req=%b addr=%h exp req=1 addr=10", imem_req, imem_addr); end
        imem_ready = 1'b1;
        if_ready = 1'b0;
        tick();
        checks++; if (if_pc !== 32'h10) begin failures++; $display("FAIL t2_if_pc got=%h exp=10", if_pc); end
        checks++; if (if_instr !== 32'hFFFF_FFEF) begin failures++; $display("FAIL t2_instr got=%h exp=ffffffef", if_instr); end
        checks++; if (imem_addr !== 32'h14) begin failures++; $display("FAIL t2_pc_step got=%h exp=14", imem_addr); end
    endtask

    task automatic test_decode_stall();
        for (int k = 0; k < 5; k++) begin
            checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h10, 32'hFFFF_FFEF}) begin failures++; $display("FAIL t3_hold[%0d] got v=%b pc=%h instr=%h", k, if_valid, if_pc, if_instr); end
            checks++; if ({imem_req, imem_addr} !== {1'b0, 32'h14}) begin failures++; $display("FAIL t3_req[%0d] got req=%b addr=%h exp req=0 addr=14", k, imem_req, imem_addr); end
            tick();
        end
        checks++; if (dbg_state !== S_HOLD) begin failures++; $display("FAIL t3_still_hold got=%0d exp=%0d", dbg_state, S_HOLD); end
        if_ready = 1'b1;
        tick();
        checks++; if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h14}) begin failures++; $display("FAIL t3_resume got v=%b req=%b addr=%h exp v=0 req=1 addr=14", if_valid, imem_req, imem_addr); end
    endtask

    task automatic test_redirect();
        redirect = 1'b1;
        redirect_pc = 32'h8;
        tick();
        checks++; if ({if_valid, imem_addr} !== {1'b0, 32'h8}) begin failures++; $display("FAIL t4_to8 got v=%b addr=%h exp v=0 addr=8", if_valid, imem_addr); end
        redirect_pc = 32'h40;
        tick();
        checks++; if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h40}) begin failures++; $display("FAIL t4_discard got v=%b req=%b addr=%h exp v=0 req=1 addr=40", if_valid, imem_req, imem_addr); end
        redirect = 1'b0;
        tick();
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h40, 32'hFFFF_FFBF}) begin failures++; $display("FAIL t4_handoff got v=%b pc=%h instr=%h exp v=1 pc=40 instr=ffffffbf", if_valid, if_pc, if_instr); end
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        checks++; if ({if_valid, dbg_state, imem_addr} !== {1'b0, S_FETCH, 32'h100}) begin failures++; $display("FAIL t4_over_ready got v=%b st=%0d addr=%h exp v=0 st=1 addr=100", if_valid, dbg_state, imem_addr); end
    endtask

    task automatic test_misalign();
        redirect_pc = 32'h42;
        tick();
        checks++; if ({misalign_err, dbg_state, imem_req, if_valid} !== {1'b1, S_ERROR, 1'b0, 1'b0}) begin failures++; $display("FAIL t5_err got err=%b st=%0d req=%b v=%b exp 1/3/0/0", misalign_err, dbg_state, imem_req, if_valid); end
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL t5_pc_kept got=%h exp=100", imem_addr); end
        redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if ({dbg_state, imem_req, imem_addr} !== {S_ERROR, 1'b0, 32'h100}) begin failures++; $display("FAIL t5_ignored got st=%0d req=%b addr=%h exp st=3 req=0 addr=100", dbg_state, imem_req, imem_addr); end
        reset_n = 1'b0;
        #1;
        checks++; if ({misalign_err, dbg_state, imem_addr} !== {1'b0, S_IDLE, 32'h0}) begin failures++; $display("FAIL t5_reset got err=%b st=%0d addr=%h exp 0/0/0", misalign_err, dbg_state, imem_addr); end
        redirect = 1'b1;
        redirect_pc = 32'h80;
        tick();
        checks++; if ({dbg_state, imem_addr} !== {S_IDLE, 32'h0}) begin failures++; $display("FAIL t5_redir_in_reset got st=%0d addr=%h exp st=0 addr=0", dbg_state, imem_addr); end
        redirect = 1'b0;
        reset_n = 1'b1;
        tick();
        checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin failures++; $display("FAIL t5_restart got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    endtask

    task automatic test_wrap_and_async_reset();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL t6_top got=%h exp=fffffffc", imem_addr); end
        tick();
        checks++; if ({if_pc, if_instr, imem_addr} !== {32'hFFFF_FFFC, 32'h3, 32'h0}) begin failures++; $display("FAIL t6_wrap got pc=%h instr=%h addr=%h exp fffffffc/3/0", if_pc, if_instr, imem_addr); end
        tick();
        checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin failures++; $display("FAIL t6_fetch0 got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
        reset_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL t6_async_req got=%b exp=0", imem_req); end
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        checks++; if ({if_valid, if_instr} !== {1'b1, 32'hFFC4_1303}) begin failures++; $display("FAIL t6_refetch got v=%b instr=%h exp v=1 instr=ffc41303", if_valid, if_instr); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if ({if_valid, if_instr, if_pc} !== {1'b0, 32'h0, 32'h0}) begin failures++; $display("FAIL t6_async_valid got v=%b instr=%h pc=%h exp 0/0/0", if_valid, if_instr, if_pc); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_mem_stall();
        test_decode_stall();
        test_redirect();
        test_misalign();
        test_wrap_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
